// File: rtl/ece369_pipe_pkg.sv
// ----------------------------------------------------------------------------
// ece369_pipe_pkg
// Shared definitions for the six-stage MIPS pipeline (IF, ID, EX1, EX2, MEM,
// WB) hazard control logic.
//   REG_IDX_W       width of a register index
//   SAD_CYCLES_DEF  default minimum spacing between two SAD issues
//   hazard_state_e  SAD structural-hazard state (IDLE / SAD_BUSY)
//   hazard_ctrl_t   bundle of the write-enable / flush controls
//   CTRL_IDLE, CTRL_STALL, CTRL_FLUSH  the three control bundles
//   loadUseMatch()  load-use dependency test against one later stage
// ----------------------------------------------------------------------------
package ece369_pipe_pkg;

  localparam int REG_IDX_W      = 5;
  localparam int SAD_CYCLES_DEF = 4;

  typedef enum logic {
    IDLE     = 1'b0,
    SAD_BUSY = 1'b1
  } hazard_state_e;

  typedef struct packed {
    logic pcWrite;
    logic ifIdWrite;
    logic ifIdFlush;
    logic idEx1Flush;
    logic ex1Ex2Flush;
  } hazard_ctrl_t;

  // Normal flow: everything loads, nothing is squashed.
  localparam hazard_ctrl_t CTRL_IDLE  = '{pcWrite: 1'b1, ifIdWrite: 1'b1,
                                         ifIdFlush: 1'b0, idEx1Flush: 1'b0,
                                         ex1Ex2Flush: 1'b0};
  // Stall: freeze PC and IF_ID, inject a bubble into ID_EX1.
  localparam hazard_ctrl_t CTRL_STALL = '{pcWrite: 1'b0, ifIdWrite: 1'b0,
                                         ifIdFlush: 1'b0, idEx1Flush: 1'b1,
                                         ex1Ex2Flush: 1'b0};
  // Jump resolved in EX2: keep fetching the target, squash the three
  // younger wrong-path instructions.
  localparam hazard_ctrl_t CTRL_FLUSH = '{pcWrite: 1'b1, ifIdWrite: 1'b1,
                                         ifIdFlush: 1'b1, idEx1Flush: 1'b1,
                                         ex1Ex2Flush: 1'b1};

  // A load in a later stage blocks the ID instruction when it really writes
  // a register other than $0 that the ID instruction really reads.
  function automatic logic loadUseMatch(
    input logic                 memRead,
    input logic                 regWrite,
    input logic [REG_IDX_W-1:0] dst,
    input logic [REG_IDX_W-1:0] rs,
    input logic [REG_IDX_W-1:0] rt,
    input logic                 useRs,
    input logic                 useRt
  );
    return memRead && regWrite && (dst != '0) &&
           ((useRs && (rs == dst)) || (useRt && (rt == dst)));
  endfunction

endpackage

// File: rtl/sad_busy_counter.sv
// ----------------------------------------------------------------------------
// sad_busy_counter
// Loadable down-counter that tracks how long the iterative SAD datapath is
// still occupied. It counts down to zero and holds there.
// Ports:
//   clk_i      pipeline clock
//   reset_ni   synchronous active-low reset
//   load_i     load load_val_i this cycle (a SAD issues)
//   load_val_i value to load
//   state_o    IDLE when the count is zero, SAD_BUSY otherwise
//   busy_o     count is nonzero
// ----------------------------------------------------------------------------
module sad_busy_counter
  import ece369_pipe_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output hazard_state_e    state_o,
  output logic             busy_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // A new issue reloads the count; otherwise it drains by one per cycle and
  // sticks at zero so it can never wrap back into a busy value.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // The count is the whole state; reset abandons any SAD in flight.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // State and busy flag are decoded straight from the registered count.
  always_comb begin
    busy_o  = (cnt_q != '0);
    state_o = busy_o ? SAD_BUSY : IDLE;
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Hazard and stall/flush controller for the six-stage MIPS pipeline with the
// custom SAD instruction. Resolves load-use hazards (load in EX1 or EX2),
// the structural hazard of the iterative SAD unit and control flushes for
// jumps resolved in EX2. Priority: flush > load stall > SAD stall.
// Optional build macro: HAZARD_STATS_EN adds saturating 32-bit counters
// stall_cycles and flush_count.
// Ports:
//   Clk, Reset                  clock, synchronous active-low reset
//   rs_ID, rt_ID, use_rs_ID, use_rt_ID, sad_ID   ID-stage instruction info
//   MemRead_EX1, RegWrite_EX1, RegDst1Result_EX1 EX1-stage load info
//   MemRead_EX2, RegWrite_EX2, RegDst1Result_EX2 EX2-stage load info
//   Jump_EX2, JR_EX2            taken jump resolved in EX2
//   PCWrite, IF_ID_Write        load enables
//   IF_ID_Flush, ID_EX1_Flush, EX1_EX2_Flush     control-bit squash
//   sad_busy                    SAD unit occupied
//   stall_cycles, flush_count   statistics (HAZARD_STATS_EN only)
// ----------------------------------------------------------------------------
module pipeline_hazard_ctrl
  import ece369_pipe_pkg::*;
#(
  parameter int SAD_CYCLES = SAD_CYCLES_DEF,
  parameter int CNT_W      = 4
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic [REG_IDX_W-1:0] rs_ID,
  input  logic [REG_IDX_W-1:0] rt_ID,
  input  logic                 use_rs_ID,
  input  logic                 use_rt_ID,
  input  logic                 sad_ID,
  input  logic                 MemRead_EX1,
  input  logic                 RegWrite_EX1,
  input  logic [REG_IDX_W-1:0] RegDst1Result_EX1,
  input  logic                 MemRead_EX2,
  input  logic                 RegWrite_EX2,
  input  logic [REG_IDX_W-1:0] RegDst1Result_EX2,
  input  logic                 Jump_EX2,
  input  logic                 JR_EX2,
  output logic                 PCWrite,
  output logic                 IF_ID_Write,
  output logic                 IF_ID_Flush,
  output logic                 ID_EX1_Flush,
  output logic                 EX1_EX2_Flush,
  output logic                 sad_busy
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]          stall_cycles,
  output logic [31:0]          flush_count
`endif
);

  logic          loadMatchEx1;
  logic          loadMatchEx2;
  logic          loadStall;
  logic          sadStall;
  logic          flushReq;
  logic          sadIssue;
  logic          cntBusy;
  hazard_state_e sadState;
  hazard_ctrl_t  ctrl;

  // Hazard detection. A dependent load in EX1 keeps matching after it moves
  // into EX2, so it naturally stalls two cycles without any extra state.
  always_comb begin
    loadMatchEx1 = loadUseMatch(MemRead_EX1, RegWrite_EX1, RegDst1Result_EX1,
                                rs_ID, rt_ID, use_rs_ID, use_rt_ID);
    loadMatchEx2 = loadUseMatch(MemRead_EX2, RegWrite_EX2, RegDst1Result_EX2,
                                rs_ID, rt_ID, use_rs_ID, use_rt_ID);
    loadStall    = loadMatchEx1 || loadMatchEx2;
    sadStall     = sad_ID && (sadState == SAD_BUSY);
    flushReq     = Jump_EX2 || JR_EX2;
    sadIssue     = sad_ID && !flushReq && !loadStall && !sadStall;
  end

  // The busy counter only loads on a real issue, so a SAD held back by a
  // load-use stall or squashed by a flush never reserves the unit. A flush
  // deliberately leaves an already-running count alone.
  sad_busy_counter #(
    .CNT_W (CNT_W)
  ) u_sad_busy_counter (
    .clk_i      (Clk),
    .reset_ni   (Reset),
    .load_i     (sadIssue),
    .load_val_i (CNT_W'(SAD_CYCLES - 1)),
    .state_o    (sadState),
    .busy_o     (cntBusy)
  );

  // Control selection by priority; while reset is asserted the pipeline sees
  // plain IDLE controls whatever the other inputs say.
  always_comb begin
    ctrl = CTRL_IDLE;
    if (!Reset) begin
      ctrl = CTRL_IDLE;
    end else if (flushReq) begin
      ctrl = CTRL_FLUSH;
    end else if (loadStall || sadStall) begin
      ctrl = CTRL_STALL;
    end
  end

  // Unpack the control bundle onto the individual pipeline-register enables.
  always_comb begin
    PCWrite       = ctrl.pcWrite;
    IF_ID_Write   = ctrl.ifIdWrite;
    IF_ID_Flush   = ctrl.ifIdFlush;
    ID_EX1_Flush  = ctrl.idEx1Flush;
    EX1_EX2_Flush = ctrl.ex1Ex2Flush;
    sad_busy      = Reset && cntBusy;
  end

`ifdef HAZARD_STATS_EN
  logic [31:0] stallCnt_q;
  logic [31:0] flushCnt_q;
  logic        stallEvent;
  logic        flushEvent;

  // Events are taken from the control actually presented, so a stall that
  // loses to a flush is not counted as a stall.
  always_comb begin
    stallEvent = Reset && !flushReq && (loadStall || sadStall);
    flushEvent = Reset && flushReq;
  end

  // Saturating statistics counters; they pin at all-ones instead of wrapping.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      stallCnt_q <= '0;
      flushCnt_q <= '0;
    end else begin
      if (stallEvent && (stallCnt_q != 32'hFFFF_FFFF)) begin
        stallCnt_q <= stallCnt_q + 32'd1;
      end
      if (flushEvent && (flushCnt_q != 32'hFFFF_FFFF)) begin
        flushCnt_q <= flushCnt_q + 32'd1;
      end
    end
  end

  assign stall_cycles = stallCnt_q;
  assign flush_count  = flushCnt_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
// Directed scoreboard bench for pipeline_hazard_ctrl (SAD_CYCLES = 4).
// Each vector pushes its hand-computed expected control word
// {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX1_Flush, EX1_EX2_Flush, sad_busy}
// into a queue; a monitor pops and compares it on the following negedge.
// ----------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

  localparam logic [5:0] E_IDLE  = 6'b110000;
  localparam logic [5:0] E_IDLEB = 6'b110001;
  localparam logic [5:0] E_STALL = 6'b000100;
  localparam logic [5:0] E_STALB = 6'b000101;
  localparam logic [5:0] E_FLUSH = 6'b111110;
  localparam logic [5:0] E_FLUSB = 6'b111111;

  logic       Clk;
  logic       Reset;
  logic [4:0] rs_ID, rt_ID;
  logic       use_rs_ID, use_rt_ID, sad_ID;
  logic       MemRead_EX1, RegWrite_EX1;
  logic [4:0] RegDst1Result_EX1;
  logic       MemRead_EX2, RegWrite_EX2;
  logic [4:0] RegDst1Result_EX2;
  logic       Jump_EX2, JR_EX2;
  logic       PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX1_Flush, EX1_EX2_Flush;
  logic       sad_busy;
`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cycles, flush_count;
`endif

  int compCount = 0;
  int failCount = 0;

  logic [5:0] expQ[$];
  string      nameQ[$];

  pipeline_hazard_ctrl #(
    .SAD_CYCLES (4),
    .CNT_W      (4)
  ) dut (
    .Clk               (Clk),
    .Reset             (Reset),
    .rs_ID             (rs_ID),
    .rt_ID             (rt_ID),
    .use_rs_ID         (use_rs_ID),
    .use_rt_ID         (use_rt_ID),
    .sad_ID            (sad_ID),
    .MemRead_EX1       (MemRead_EX1),
    .RegWrite_EX1      (RegWrite_EX1),
    .RegDst1Result_EX1 (RegDst1Result_EX1),
    .MemRead_EX2       (MemRead_EX2),
    .RegWrite_EX2      (RegWrite_EX2),
    .RegDst1Result_EX2 (RegDst1Result_EX2),
    .Jump_EX2          (Jump_EX2),
    .JR_EX2            (JR_EX2),
    .PCWrite           (PCWrite),
    .IF_ID_Write       (IF_ID_Write),
    .IF_ID_Flush       (IF_ID_Flush),
    .ID_EX1_Flush      (ID_EX1_Flush),
    .EX1_EX2_Flush     (EX1_EX2_Flush),
    .sad_busy          (sad_busy)
`ifdef HAZARD_STATS_EN
    ,
    .stall_cycles      (stall_cycles),
    .flush_count       (flush_count)
`endif
  );

  // Free-running clock, 10 time-unit period.
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Monitor: the DUT presents a control word every cycle, so whenever a
  // vector is pending its expectation is checked away from the active edge.
  always @(negedge Clk) begin
    if (expQ.size() > 0) begin
      logic [5:0] expWord;
      logic [5:0] actWord;
      string      nm;
      expWord = expQ.pop_front();
      nm      = nameQ.pop_front();
      actWord = {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX1_Flush,
                 EX1_EX2_Flush, sad_busy};
      checkOutput(nm, 32'(actWord), 32'(expWord));
    end
  end

  // Shared comparison: steps the counters printed in the summary.
  task automatic checkOutput(input string nm, input logic [31:0] act,
                             input logic [31:0] exp);
    compCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Return every input to a quiet, out-of-reset cycle.
  task automatic clearInputs();
    Reset             = 1'b1;
    rs_ID             = 5'd0;
    rt_ID             = 5'd0;
    use_rs_ID         = 1'b0;
    use_rt_ID         = 1'b0;
    sad_ID            = 1'b0;
    MemRead_EX1       = 1'b0;
    RegWrite_EX1      = 1'b0;
    RegDst1Result_EX1 = 5'd0;
    MemRead_EX2       = 1'b0;
    RegWrite_EX2      = 1'b0;
    RegDst1Result_EX2 = 5'd0;
    Jump_EX2          = 1'b0;
    JR_EX2            = 1'b0;
  endtask

  // Inputs are already set; queue the expectation and let one cycle pass.
  task automatic applyStimulus(input string nm, input logic [5:0] exp);
    expQ.push_back(exp);
    nameQ.push_back(nm);
    @(posedge Clk);
    #1;
  endtask

  task automatic setLoadEx1(input logic [4:0] dst);
    MemRead_EX1 = 1'b1; RegWrite_EX1 = 1'b1; RegDst1Result_EX1 = dst;
  endtask

  task automatic setLoadEx2(input logic [4:0] dst);
    MemRead_EX2 = 1'b1; RegWrite_EX2 = 1'b1; RegDst1Result_EX2 = dst;
  endtask

  initial begin
    clearInputs();
    @(posedge Clk);
    #1;

    // Reset with every hazard active: outputs must still be IDLE.
    Reset = 1'b0; sad_ID = 1'b1; JR_EX2 = 1'b1;
    use_rs_ID = 1'b1; rs_ID = 5'd8; setLoadEx1(5'd8);
    applyStimulus("reset_forced_idle0", E_IDLE);
    applyStimulus("reset_forced_idle1", E_IDLE);
    clearInputs();
    applyStimulus("after_reset_idle", E_IDLE);

    // Load-use at EX1 distance: two stall cycles, then normal flow.
    use_rs_ID = 1'b1; rs_ID = 5'd8; setLoadEx1(5'd8);
    applyStimulus("loaduse_ex1_c1", E_STALL);
    clearInputs(); use_rs_ID = 1'b1; rs_ID = 5'd8; setLoadEx2(5'd8);
    applyStimulus("loaduse_ex1_c2", E_STALL);
    clearInputs(); use_rs_ID = 1'b1; rs_ID = 5'd8;
    applyStimulus("loaduse_ex1_done", E_IDLE);

    // rt match, rt not actually read, and a non-writing load.
    clearInputs(); use_rt_ID = 1'b1; rt_ID = 5'd17; setLoadEx1(5'd17);
    applyStimulus("loaduse_rt", E_STALL);
    clearInputs(); rt_ID = 5'd17; setLoadEx1(5'd17);
    applyStimulus("rt_not_used", E_IDLE);
    clearInputs(); use_rs_ID = 1'b1; rs_ID = 5'd9; setLoadEx2(5'd9);
    RegWrite_EX2 = 1'b0;
    applyStimulus("no_regwrite", E_IDLE);

    // $0 is never a hazard source.
    clearInputs(); use_rt_ID = 1'b1; rt_ID = 5'd0; setLoadEx2(5'd0);
    applyStimulus("reg0_excluded", E_IDLE);

    // Two consecutive SADs: second held 3 cycles, issues 4 cycles apart.
    clearInputs(); sad_ID = 1'b1;
    applyStimulus("sad_issue1", E_IDLE);
    applyStimulus("sad_hold1", E_STALB);
    applyStimulus("sad_hold2", E_STALB);
    applyStimulus("sad_hold3", E_STALB);
    applyStimulus("sad_issue2", E_IDLE);
    clearInputs();
    applyStimulus("sad_busy_a", E_IDLEB);
    applyStimulus("sad_busy_b", E_IDLEB);
    applyStimulus("sad_busy_c", E_IDLEB);
    applyStimulus("sad_drained", E_IDLE);

    // Flush beats load-use and blocks a SAD issue; counter stays idle.
    clearInputs(); JR_EX2 = 1'b1; sad_ID = 1'b1;
    use_rs_ID = 1'b1; rs_ID = 5'd8; setLoadEx1(5'd8);
    applyStimulus("flush_priority", E_FLUSH);
    clearInputs();
    applyStimulus("flush_no_issue", E_IDLE);

    // Reset in the middle of a busy window.
    sad_ID = 1'b1;
    applyStimulus("rst_sad_issue", E_IDLE);
    clearInputs();
    applyStimulus("rst_cnt3", E_IDLEB);
    Reset = 1'b0; sad_ID = 1'b1; JR_EX2 = 1'b1;
    applyStimulus("rst_mid_busy", E_IDLE);
    clearInputs(); sad_ID = 1'b1;
    applyStimulus("rst_then_issue", E_IDLE);

    // A flush while busy leaves the running count alone.
    clearInputs(); Jump_EX2 = 1'b1;
    applyStimulus("flush_keeps_cnt", E_FLUSB);
    clearInputs();
    applyStimulus("keep_cnt1", E_IDLEB);
    applyStimulus("keep_cnt0", E_IDLEB);
    applyStimulus("keep_drained", E_IDLE);

    // SAD behind a load-use stall loads the counter only when it issues.
    sad_ID = 1'b1; use_rs_ID = 1'b1; rs_ID = 5'd4; setLoadEx1(5'd4);
    applyStimulus("sad_load_stall1", E_STALL);
    clearInputs(); sad_ID = 1'b1; use_rs_ID = 1'b1; rs_ID = 5'd4;
    setLoadEx2(5'd4);
    applyStimulus("sad_load_stall2", E_STALL);
    clearInputs(); sad_ID = 1'b1;
    applyStimulus("sad_late_issue", E_IDLE);
    clearInputs();
    applyStimulus("sad_late_busy", E_IDLEB);
    applyStimulus("sad_late_busy2", E_IDLEB);
    applyStimulus("sad_late_busy3", E_IDLEB);
    applyStimulus("sad_late_done", E_IDLE);

`ifdef HAZARD_STATS_EN
    // Statistics: clear, then 5 stall cycles and 2 flushes.
    clearInputs(); Reset = 1'b0;
    applyStimulus("stats_reset", E_IDLE);
    clearInputs();
    checkOutput("stats_stall_zero", stall_cycles, 32'd0);
    checkOutput("stats_flush_zero", flush_count, 32'd0);
    use_rt_ID = 1'b1; rt_ID = 5'd12; setLoadEx1(5'd12);
    for (int i = 0; i < 5; i++) applyStimulus("stats_stall", E_STALL);
    clearInputs(); JR_EX2 = 1'b1;
    applyStimulus("stats_flush1", E_FLUSH);
    clearInputs(); Jump_EX2 = 1'b1;
    applyStimulus("stats_flush2", E_FLUSH);
    clearInputs();
    applyStimulus("stats_idle", E_IDLE);
    checkOutput("stats_stall_5", stall_cycles, 32'd5);
    checkOutput("stats_flush_2", flush_count, 32'd2);
`endif

    // Give the monitor a chance to drain, then confirm nothing was lost.
    @(negedge Clk);
    #1;
    checkOutput("queue_drained", 32'(expQ.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compCount, failCount);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Hazard and stall/flush controller for the six-stage MIPS pipeline (IF, ID, EX1, EX2, MEM, WB) with the custom SAD motion-search instruction. It watches the ID, EX1 and EX2 stages and drives the write-enable and flush controls back into the PC, IF_ID, ID_EX1 and EX1_EX2 registers. This runs opposite to the forward data flow through the pipeline registers. It resolves three hazards:
- load-use data hazards;
- the structural hazard of the iterative SAD datapath;
- control flushes for jumps resolved in EX2.

## Interface
Parameters:
- SAD_CYCLES, 4, minimum spacing in cycles between two SAD issues (legal range 2..15).
- CNT_W, 4, width of the SAD busy counter.

Ports:
- Clk  in  1  pipeline clock; single clock domain.
- Reset  in  1  synchronous, active-low reset, sampled on posedge Clk.
- rs_ID, rt_ID  in  5  source register indices of the instruction in ID.
- use_rs_ID, use_rt_ID  in  1  ID instruction actually reads rs / rt.
- sad_ID  in  1  ID instruction is SAD.
- MemRead_EX1, RegWrite_EX1  in  1  control bits of the instruction in EX1.
- RegDst1Result_EX1  in  5  destination register of the instruction in EX1.
- MemRead_EX2, RegWrite_EX2  in  1  control bits of the instruction in EX2.
- RegDst1Result_EX2  in  5  destination register of the instruction in EX2.
- Jump_EX2, JR_EX2  in  1  taken jump (j/jal/jr) resolved in EX2.
- PCWrite  out  1  PC load enable.
- IF_ID_Write  out  1  IF_ID load enable.
- IF_ID_Flush, ID_EX1_Flush, EX1_EX2_Flush  out  1  zero the control bits captured by that register.
- sad_busy  out  1  SAD counter nonzero.

## Operation
- Load-use match in stage S (S = EX1 or EX2) requires all of:
  - MemRead_S && RegWrite_S && RegDst1Result_S != 0;
  - and either (use_rs_ID && rs_ID == RegDst1Result_S) or (use_rt_ID && rt_ID == RegDst1Result_S).
- load_stall = match in EX1 or match in EX2.
  - A dependent load in EX1 therefore stalls 2 cycles, and one in EX2 stalls 1 cycle, without extra state.
- sad_stall = sad_ID && (sad_cnt != 0).
- flush = Jump_EX2 || JR_EX2.
- Priority is flush > load_stall > sad_stall.
  - Flush: PCWrite=1, IF_ID_Write=1, IF_ID_Flush=1, ID_EX1_Flush=1, EX1_EX2_Flush=1.
  - Any stall: PCWrite=0, IF_ID_Write=0, ID_EX1_Flush=1, IF_ID_Flush=0, EX1_EX2_Flush=0.
  - Otherwise (IDLE outputs): PCWrite=1, IF_ID_Write=1, all flushes 0.
- SAD state machine, with sad_cnt (CNT_W bits) as state:
  - IDLE: sad_cnt == 0.
  - SAD_BUSY: sad_cnt > 0.
  - Issue event: sad_ID && !flush && !load_stall && !sad_stall. On it, sad_cnt <= SAD_CYCLES-1 (IDLE -> SAD_BUSY).
  - Otherwise, if sad_cnt != 0, sad_cnt decrements by 1. It never wraps below 0.
  - sad_busy = (sad_cnt != 0).
- A flush does not clear sad_cnt. The rule is conservative: a squashed SAD costs only idle cycles, never correctness.
- Register $0 is never a hazard source.

## Timing
- All outputs are combinational from the current inputs and sad_cnt; they take effect at the next posedge Clk.
- sad_cnt is the only registered state.
- Reset low at a posedge:
  - sad_cnt <= 0 (and the statistics counters <= 0 when compiled in).
  - While Reset is low, outputs are forced to IDLE values and sad_busy=0, regardless of the other inputs.
- Reset mid-SAD_BUSY abandons the count; the next cycle is IDLE.
- Back-to-back SAD instructions issue exactly SAD_CYCLES cycles apart.
- A SAD stalled by a load-use hazard does not load the counter until its issue cycle.
- Simultaneous load-use and flush: the flush wins, and no stall occurs that cycle.

## Configuration
- Macro HAZARD_STATS_EN.
- Defined: adds 32-bit saturating counters with these outputs:
  - stall_cycles (out 32): +1 per cycle with any stall.
  - flush_count (out 32): +1 per flush cycle.
  - Both counters hold at 32'hFFFFFFFF.
- Undefined: the counters and their ports do not exist, and there is no other behavioural difference.

## Structure
- Shared package ece369_pipe_pkg holds:
  - the REG_IDX_W = 5 constant;
  - the SAD_CYCLES default;
  - the hazard-state typedef (IDLE, SAD_BUSY);
  - the IDLE-output constant bundle.
- One sub-module, sad_busy_counter: a loadable down-counter with saturation at 0, and the busy flag.

## Test plan
- Load-use, EX1 distance: lw $8 in EX1 (MemRead_EX1=1, RegDst1Result_EX1=8), add in ID reading rs=8. Required: PCWrite=0 and ID_EX1_Flush=1 for exactly 2 cycles, then normal flow.
- $0 exclusion: lw $0 in EX2, ID reading rt=0. Required: no stall.
- SAD spacing, SAD_CYCLES=4: two consecutive SAD instructions. Required: second held 3 cycles; issues are 4 cycles apart; sad_busy high for 3 cycles after the first.
- Flush priority: JR_EX2=1 in the same cycle as a load-use match. Required: all three flushes=1, PCWrite=1, no stall; the counter is unchanged.
- Reset mid-busy: Reset low at sad_cnt=2. Required: next cycle sad_cnt=0, IDLE outputs, and an immediate SAD issue is allowed.
- With HAZARD_STATS_EN: 5 stall cycles and 2 flushes. Required: stall_cycles=5 and flush_count=2; both read 0 after reset.
